gray_code_counter: RTL and testbench
====================================

Name: gray_code_counter

Overview:
- Parametrised, registered up/down counter that presents its value in both Gray and binary form. It is the sequential successor of our combinational code converters.
- Feeds Gray-coded pointers to clock-domain-crossing logic and to lab test fixtures.
- Supports wrap or saturate at the limits, and a parallel load given in Gray code.

Parameters:
- WIDTH, 4, counter width in bits; must be at least 2.
- WRAP, 1, 1 means wrap around at the limits, 0 means saturate at the limits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; the counter steps once per cycle while en=1.
- up  input  1  direction; 1 counts up, 0 counts down.
- ld  input  1  parallel load strobe.
- ld_gray  input  WIDTH  load value, Gray-coded.
- gray_o  output  WIDTH  registered count, Gray-coded.
- bin_o  output  WIDTH  registered count, binary.
- tc_o  output  1  registered terminal-count pulse.

Behaviour:
- Reset (rst=1 at a rising edge): bin_o=0, gray_o=0, tc_o=0. Reset takes priority over every other input.
- Priority per edge: rst, then ld, then en. With all three low, the count holds and tc_o is 0.
- Load:
  - bin_o <= gray2bin(ld_gray), where bit b[WIDTH-1]=g[WIDTH-1] and each lower bit b[i]=b[i+1]^g[i].
  - gray_o <= ld_gray.
  - tc_o <= 0.
  - Any WIDTH-bit value is legal. Latency is 1 cycle.
- Count (en=1, ld=0):
  - Up: next = bin_o + 1. Down: next = bin_o - 1. All arithmetic is WIDTH-bit, unsigned.
  - Both outputs update on the same edge. gray_o is next ^ (next >> 1), taken from the next-state value, never from the old bin_o. Latency is 1 cycle.
- Limit event: en=1, ld=0, and either (up=1 and bin_o is all ones) or (up=0 and bin_o=0).
  - WRAP=1: the count wraps, all ones to 0 or 0 to all ones.
  - WRAP=0: the count holds.
  - In both modes tc_o=1 for the following cycle; otherwise tc_o=0.
  - With en held at the limit under WRAP=0, tc_o stays 1 on every cycle.
- Gray invariant: outside reset and load, consecutive gray_o values differ in exactly one bit on every step, including the wrap step. They differ in zero bits on hold or saturation.
- Direction may change on any cycle with no bubble.
- Reset mid-count: the next cycle shows 0; counting resumes from 0 on the first cycle with en=1 after rst falls.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: GRAY_CNT_CHECK_EN.
- Defined:
  - Adds output err_o (1 bit, reset value 0).
  - err_o is a sticky flag. It is set when two consecutive gray_o values differ in more than one bit and the second value did not come from reset or load.
  - Only rst clears it.
- Undefined: the err_o port and its checker logic are absent; all other behaviour is identical.

Decomposition:
- Package gray_pkg holds:
  - localparam mode codes MODE_WRAP=1 and MODE_SAT=0;
  - function bin2gray(WIDTH) and function gray2bin(WIDTH), shared with the existing converters.
- One natural sub-module, gray2bin_conv: combinational, parametrised on WIDTH, used for the load path. Reset, load and counting logic stay in the top level.

Test Plan:
- WIDTH=4, WRAP=1, rst for 2 cycles -> bin_o=0, gray_o=0000, tc_o=0.
- en=1, up=1 for 16 cycles -> gray_o runs 0000, 0001, 0011, 0010, 0110, …, 1000, then 0000. The cycle after the 15->0 step shows tc_o=1; every step changes one bit.
- ld=1, ld_gray=1101 -> next cycle bin_o=1001 (9), gray_o=1101. Then en=1, up=0 -> bin_o=8, gray_o=1100.
- From 0: en=1, up=0 -> WRAP=1 gives bin_o=1111, gray_o=1000, tc_o=1. WRAP=0 holds at 0 with tc_o=1 each cycle.
- ld=1 and en=1 together with ld_gray=0110 -> load wins: bin_o=0100. Then rst=1 mid-count -> bin_o=0 on the next cycle.
- Under GRAY_CNT_CHECK_EN: force gray_o 0000 to 0011 in simulation -> err_o=1 and stays set until rst.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers and counter mode codes.
// Functions operate on GRAY_MAX_W-bit values; callers zero-extend narrower
// operands and truncate results. Upper zero bits do not disturb either
// conversion, so one definition serves every width up to GRAY_MAX_W.
package gray_pkg;

  localparam int MODE_WRAP  = 1;
  localparam int MODE_SAT   = 0;
  localparam int GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_code_counter_conv.sv
// Combinational Gray-to-binary converter used on the counter load path.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Zero-extend, convert, truncate back to WIDTH.
  always_comb begin
    bin = WIDTH'(gray2bin(GRAY_MAX_W'(gray)));
  end

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down counter with Gray and binary outputs, wrap or saturate
// at the limits, and a Gray-coded parallel load.
// Optional macro GRAY_CNT_CHECK_EN adds err_o, a sticky flag raised when
// gray_o takes a multi-bit step that did not come from reset or load.
// WIDTH must be in 2..GRAY_MAX_W.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WRAP  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_gray,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
`ifdef GRAY_CNT_CHECK_EN
  output logic             err_o,
`endif
  output logic             tc_o
);

  logic [WIDTH-1:0] ld_bin;
  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] gray_nxt;
  logic             at_max, at_min, limit;

  gray2bin_conv #(.WIDTH(WIDTH)) u_conv (
    .gray (ld_gray),
    .bin  (ld_bin)
  );

  assign at_max = &bin_o;
  assign at_min = ~|bin_o;
  assign limit  = en & ~ld & (up ? at_max : at_min);

  // Next-state select: load beats count; saturation holds at the limit.
  always_comb begin
    bin_nxt = bin_o;
    if (ld)                                 bin_nxt = ld_bin;
    else if (en && !(limit && WRAP == MODE_SAT))
      bin_nxt = up ? bin_o + WIDTH'(1) : bin_o - WIDTH'(1);
    // Gray comes from the next-state value; a load takes ld_gray verbatim.
    gray_nxt = ld ? ld_gray : WIDTH'(bin2gray(GRAY_MAX_W'(bin_nxt)));
  end

  // Count registers; reset wins over load and enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_o  <= '0;
      gray_o <= '0;
      tc_o   <= 1'b0;
    end else begin
      bin_o  <= bin_nxt;
      gray_o <= gray_nxt;
      tc_o   <= limit;
    end
  end

`ifdef GRAY_CNT_CHECK_EN
  logic [WIDTH-1:0] gray_prev;
  logic [WIDTH-1:0] gray_diff;
  logic             fresh;   // current gray_o came from reset or load

  assign gray_diff = gray_o ^ gray_prev;

  // Sticky multi-bit-step detector on the registered Gray output.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_o     <= 1'b0;
      fresh     <= 1'b1;
      gray_prev <= '0;
    end else begin
      fresh     <= ld;
      gray_prev <= gray_o;
      if (!fresh && ((gray_diff & (gray_diff - WIDTH'(1))) != '0))
        err_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed-vector bench: one wrapping and one saturating 4-bit counter
// driven in lockstep from a table of hand-computed expectations.
module tb_gray_code_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, ld;
  logic [3:0] ld_gray;
  logic [3:0] gray_w, bin_w, gray_s, bin_s;
  logic       tc_w, tc_s;
`ifdef GRAY_CNT_CHECK_EN
  logic       err_w, err_s;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gray_code_counter #(.WIDTH(4), .WRAP(1)) dut_w (
    .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .ld_gray(ld_gray),
    .gray_o(gray_w), .bin_o(bin_w),
`ifdef GRAY_CNT_CHECK_EN
    .err_o(err_w),
`endif
    .tc_o(tc_w));

  gray_code_counter #(.WIDTH(4), .WRAP(0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .up(up), .ld(ld), .ld_gray(ld_gray),
    .gray_o(gray_s), .bin_o(bin_s),
`ifdef GRAY_CNT_CHECK_EN
    .err_o(err_s),
`endif
    .tc_o(tc_s));

  typedef struct {
    logic       rst, en, up, ld;
    logic [3:0] lg;
    logic [3:0] bw, gw; logic tw;   // expected, wrapping instance
    logic [3:0] bs, gs; logic ts;   // expected, saturating instance
    logic       onebit;             // wrap instance must step exactly one bit
  } vec_t;

  vec_t tv[$];

  task automatic push(input logic r, e, u, l, input logic [3:0] lg,
                      input logic [3:0] bw, gw, input logic tw,
                      input logic [3:0] bs, gs, input logic ts,
                      input logic ob);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.ld = l; v.lg = lg;
    v.bw = bw; v.gw = gw; v.tw = tw; v.bs = bs; v.gs = gs; v.ts = ts;
    v.onebit = ob;
    tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, e, u, l, input logic [3:0] lg);
    rst = r; en = e; up = u; ld = l; ld_gray = lg;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] gt [16];
  logic [3:0] prev_g;

  initial begin
    rst = 1'b1; en = 1'b0; up = 1'b0; ld = 1'b0; ld_gray = 4'h0;
    gt = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
           4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

    //    rst en up ld lg     bw    gw    tw    bs    gs    ts  1bit
    push(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0);
    push(1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0);
    for (int k = 1; k < 16; k++)
      push(0, 1, 1, 0, 4'h0, 4'(k), gt[k], 0, 4'(k), gt[k], 0, 1);
    push(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 1, 4'hF, 4'h8, 1, 1);  // 15 -> 0 / hold
    push(0, 0, 0, 1, 4'hD, 4'h9, 4'hD, 0, 4'h9, 4'hD, 0, 0);  // load 1101
    push(0, 1, 0, 0, 4'h0, 4'h8, 4'hC, 0, 4'h8, 4'hC, 0, 1);  // down
    push(0, 0, 0, 1, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0);  // load 0
    push(0, 1, 0, 0, 4'h0, 4'hF, 4'h8, 1, 4'h0, 4'h0, 1, 1);  // 0 -> F / hold
    push(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 1, 4'h1, 4'h1, 0, 1);  // direction flip
    push(0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 4'h1, 4'h1, 0, 0);  // idle hold
    push(0, 1, 1, 1, 4'h6, 4'h4, 4'h6, 0, 4'h4, 4'h6, 0, 0);  // load beats en
    push(0, 1, 1, 0, 4'h0, 4'h5, 4'h7, 0, 4'h5, 4'h7, 0, 1);
    push(1, 1, 1, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0);  // rst mid-count
    push(0, 0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 4'h0, 0, 0);
    push(0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 0, 4'h1, 4'h1, 0, 1);  // resumes from 0
    push(0, 0, 0, 1, 4'h8, 4'hF, 4'h8, 0, 4'hF, 4'h8, 0, 0);  // load 1000 = 15
    push(0, 1, 1, 0, 4'h0, 4'h0, 4'h0, 1, 4'hF, 4'h8, 1, 1);
    push(0, 1, 1, 0, 4'h0, 4'h1, 4'h1, 0, 4'hF, 4'h8, 1, 1);  // sat stays tc=1
    push(0, 1, 1, 1, 4'hB, 4'hD, 4'hB, 0, 4'hD, 4'hB, 0, 0);  // load clears tc

    prev_g = 4'h0;
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].en, tv[i].up, tv[i].ld, tv[i].lg);
      chk($sformatf("v%0d bin_w", i),  bin_w,  tv[i].bw);
      chk($sformatf("v%0d gray_w", i), gray_w, tv[i].gw);
      chk($sformatf("v%0d tc_w", i),   {3'b0, tc_w}, {3'b0, tv[i].tw});
      chk($sformatf("v%0d bin_s", i),  bin_s,  tv[i].bs);
      chk($sformatf("v%0d gray_s", i), gray_s, tv[i].gs);
      chk($sformatf("v%0d tc_s", i),   {3'b0, tc_s}, {3'b0, tv[i].ts});
      if (tv[i].onebit)
        chk($sformatf("v%0d gray_w onebit", i),
            4'($countones(gray_w ^ prev_g)), 4'd1);
      prev_g = gray_w;
    end

    // Hold en at the bottom limit for three cycles.
    drive(1, 0, 0, 0, 4'h0);
    drive(0, 1, 0, 0, 4'h0);
    chk("sat0 bin_w", bin_w, 4'hF); chk("sat0 tc_w", {3'b0, tc_w}, 4'd1);
    chk("sat0 bin_s", bin_s, 4'h0); chk("sat0 tc_s", {3'b0, tc_s}, 4'd1);
    drive(0, 1, 0, 0, 4'h0);
    chk("sat1 bin_w", bin_w, 4'hE); chk("sat1 tc_w", {3'b0, tc_w}, 4'd0);
    chk("sat1 bin_s", bin_s, 4'h0); chk("sat1 tc_s", {3'b0, tc_s}, 4'd1);
    drive(0, 1, 0, 0, 4'h0);
    chk("sat2 gray_w", gray_w, 4'hB); chk("sat2 gray_s", gray_s, 4'h0);
    chk("sat2 tc_s", {3'b0, tc_s}, 4'd1);

`ifdef GRAY_CNT_CHECK_EN
    chk("err_w clean", {3'b0, err_w}, 4'd0);
    chk("err_s clean", {3'b0, err_s}, 4'd0);
    drive(1, 0, 0, 0, 4'h0);
    drive(0, 0, 0, 0, 4'h0);
    force dut_w.gray_o = 4'b0011;
    @(posedge clk);
    @(negedge clk);
    release dut_w.gray_o;
    chk("err_w set", {3'b0, err_w}, 4'd1);
    drive(0, 0, 0, 0, 4'h0);
    chk("err_w sticky", {3'b0, err_w}, 4'd1);
    drive(0, 0, 0, 1, 4'h5);
    chk("err_w ld no clear", {3'b0, err_w}, 4'd1);
    drive(1, 0, 0, 0, 4'h0);
    chk("err_w rst clear", {3'b0, err_w}, 4'd0);
    chk("err_s untouched", {3'b0, err_s}, 4'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
